// File: rtl/boid_frame_updater.sv
// boid_frame_updater: rebuilds a boid framebuffer once per frame_start_i.
// Each accepted frame either erases the pixels drawn in the previous frame
// (CLEAR_MODE=0) or wipes the whole screen (CLEAR_MODE=1). It then scans every
// boid through the external x/y/colour mux and plots one pixel per boid.
// Ports:
//   clk_i, rst_i            single clock, synchronous active-high reset
//   frame_start_i           one-cycle rebuild request
//   boid_sel_o              index driving the external boid mux
//   boid_x_i/_y_i/_color_i  selected boid's data (combinational from boid_sel_o)
//   fb_addr_o/_data_o/_we_o framebuffer write port
//   busy_o, done_o          rebuild in progress / one-cycle completion pulse
//   skip_count_o            out-of-bounds boids in the last frame (saturating)
//   overrun_o               sticky: frame_start_i seen while busy
module boid_frame_updater #(
  parameter int unsigned NUM_BOIDS   = 32,
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned COLOR_W     = 1,
  parameter int unsigned CLEAR_MODE  = 0,
  parameter int unsigned CLEAR_COLOR = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         frame_start_i,
  output logic [$clog2(NUM_BOIDS)-1:0] boid_sel_o,
  input  logic [9:0]                   boid_x_i,
  input  logic [8:0]                   boid_y_i,
  input  logic [COLOR_W-1:0]           boid_color_i,
  output logic [ADDR_W-1:0]            fb_addr_o,
  output logic [COLOR_W-1:0]           fb_data_o,
  output logic                         fb_we_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [7:0]                   skip_count_o,
  output logic                         overrun_o
);

  localparam int unsigned IdxW = $clog2(NUM_BOIDS);
  localparam int unsigned CntW = IdxW + 1;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StClear = 3'd1;
  localparam logic [2:0] StErase = 3'd2;
  localparam logic [2:0] StDraw  = 3'd3;
  localparam logic [2:0] StFin   = 3'd4;

  localparam logic [ADDR_W-1:0]  ClrLast = ADDR_W'(SCREEN_W * SCREEN_H - 1);
  localparam logic [COLOR_W-1:0] ClrCol  = COLOR_W'(CLEAR_COLOR);

  logic [2:0]           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]    clr_q, clr_d;
  logic [NUM_BOIDS-1:0] valid_q, valid_d;
  logic [ADDR_W-1:0]    addr_q [NUM_BOIDS];
  logic [7:0]           skip_q, skip_d;
  logic                 overrun_q, overrun_d;

  // Boid sampled in the previous draw cycle; its write happens this cycle.
  logic [9:0]           px_q;
  logic [8:0]           py_q;
  logic [COLOR_W-1:0]   pc_q;

  logic [ADDR_W-1:0]    draw_addr;
  logic                 in_bounds;
  logic                 draw_wr;
  logic [IdxW-1:0]      tbl_idx;
  logic                 accept;

  assign draw_addr = ADDR_W'(px_q) + ADDR_W'(SCREEN_W) * ADDR_W'(py_q);
  assign in_bounds = (32'(px_q) < SCREEN_W) && (32'(py_q) < SCREEN_H);
  // Draw cycle 0 only samples; cycles 1..NUM_BOIDS retire boid cnt-1.
  assign draw_wr   = (state_q == StDraw) && (cnt_q != '0);
  assign tbl_idx   = IdxW'(cnt_q - 1'b1);
  assign busy_o    = (state_q == StClear) || (state_q == StErase) || (state_q == StDraw);
  assign accept    = frame_start_i && !busy_o;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_d     = clr_q;
    valid_d   = valid_q;
    skip_d    = skip_q;
    overrun_d = overrun_q || (frame_start_i && busy_o);

    case (state_q)
      StClear: begin
        if (clr_q == ClrLast) begin
          clr_d   = '0;
          cnt_d   = '0;
          state_d = StDraw;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      StErase: begin
        if (cnt_q == CntW'(NUM_BOIDS - 1)) begin
          cnt_d   = '0;
          state_d = StDraw;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDraw: begin
        if (draw_wr) begin
          valid_d[tbl_idx] = in_bounds;
          if (!in_bounds && skip_q != 8'hFF) skip_d = skip_q + 8'd1;
        end
        if (cnt_q == CntW'(NUM_BOIDS)) begin
          cnt_d   = '0;
          state_d = StFin;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFin:   state_d = StIdle;
      StIdle:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (accept) begin
      state_d = (CLEAR_MODE != 0) ? StClear : StErase;
      cnt_d   = '0;
      clr_d   = '0;
      skip_d  = '0;
    end
  end

  always_comb begin
    fb_we_o   = 1'b0;
    fb_addr_o = '0;
    fb_data_o = ClrCol;
    case (state_q)
      StClear: begin
        fb_we_o   = 1'b1;
        fb_addr_o = clr_q;
      end
      StErase: begin
        fb_we_o   = valid_q[cnt_q[IdxW-1:0]];
        fb_addr_o = addr_q[cnt_q[IdxW-1:0]];
      end
      StDraw: begin
        fb_we_o   = draw_wr && in_bounds;
        fb_addr_o = draw_addr;
        fb_data_o = pc_q;
      end
      default: ;
    endcase
  end

  assign boid_sel_o   = (state_q == StDraw) ? cnt_q[IdxW-1:0] : '0;
  assign done_o       = (state_q == StFin);
  assign skip_count_o = skip_q;
  assign overrun_o    = overrun_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      clr_q     <= '0;
      valid_q   <= '0;
      skip_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clr_q     <= clr_d;
      valid_q   <= valid_d;
      skip_q    <= skip_d;
      overrun_q <= overrun_d;
    end
  end

  // Datapath storage needs no reset: valid_q gates every use of addr_q.
  always_ff @(posedge clk_i) begin
    px_q <= boid_x_i;
    py_q <= boid_y_i;
    pc_q <= boid_color_i;
    if (draw_wr && in_bounds) addr_q[tbl_idx] <= draw_addr;
  end

endmodule

// File: doc/boid_frame_updater.md
BOID_FRAME_UPDATER -- requirements
Module: boid_frame_updater

Interface
REQ-001 SHALL have parameter NUM_BOIDS, default 32: number of boid channels scanned per frame; must be a power of two, 2..64.
REQ-002 SHALL have parameter SCREEN_W, default 640: framebuffer width in pixels.
REQ-003 SHALL have parameter SCREEN_H, default 480: framebuffer height in pixels.
REQ-004 SHALL have parameter ADDR_W, default 19: framebuffer address width; must satisfy 2^ADDR_W >= SCREEN_W*SCREEN_H.
REQ-005 SHALL have parameter COLOR_W, default 1: pixel data width.
REQ-006 SHALL have parameter CLEAR_MODE, default 0: 0 = erase the previous boid positions only; 1 = full-screen clear.
REQ-007 SHALL have parameter CLEAR_COLOR, default 0: value written when erasing or clearing.
REQ-008 SHALL have one clock and a synchronous, active-high reset: clock in 1, the single clock, all logic on its rising edge; reset in 1, synchronous active-high.
REQ-009 SHALL have port frame_start, input, 1 bit: single-cycle request to rebuild the frame (driven from screenEnd_out).
REQ-010 SHALL have port boid_sel, output, log2(NUM_BOIDS) bits: boid index that selects the external x/y/colour mux.
REQ-011 SHALL have ports boid_x (input, 10 bits), boid_y (input, 9 bits) and boid_color (input, COLOR_W bits): the selected boid's data, combinational from boid_sel.
REQ-012 SHALL have ports fb_addr (output, ADDR_W bits), fb_data (output, COLOR_W bits) and fb_we (output, 1 bit): the framebuffer write port.
REQ-013 SHALL have port busy, output, 1 bit: high while a rebuild is in progress.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when a rebuild completes.
REQ-015 SHALL have port skip_count, output, 8 bits: number of out-of-bounds boids in the last frame.
REQ-016 SHALL have port overrun, output, 1 bit: sticky flag, set when frame_start arrives while busy is high.

Function
REQ-017 SHALL implement FSM states IDLE, CLEAR, ERASE, DRAW and FIN.
REQ-018 SHALL accept frame_start only while busy=0, i.e. in IDLE or FIN.
- On acceptance: next state is ERASE (CLEAR_MODE=0) or CLEAR (CLEAR_MODE=1).
- On acceptance: skip_count is cleared to 0.
REQ-019 SHALL, in CLEAR, write CLEAR_COLOR to addresses 0..SCREEN_W*SCREEN_H-1, one per cycle with fb_we=1, then go to DRAW.
REQ-020 SHALL hold an internal table of NUM_BOIDS entries, each {valid, addr}, recording the pixel drawn for each boid in the previous frame.
REQ-021 SHALL, in ERASE, visit entries 0..NUM_BOIDS-1, exactly one per cycle.
- A valid entry produces fb_we=1, fb_addr=entry.addr, fb_data=CLEAR_COLOR.
- An invalid entry produces fb_we=0 and still consumes the cycle.
- ERASE then goes to DRAW; it always lasts exactly NUM_BOIDS cycles.
REQ-022 SHALL, in DRAW, drive boid_sel=i during draw cycle i for i=0..NUM_BOIDS-1, and register boid_x, boid_y and boid_color at the end of that cycle.
REQ-023 SHALL issue the write for boid i in draw cycle i+1, pipelined so that DRAW lasts exactly NUM_BOIDS+1 cycles.
REQ-024 SHALL compute the draw address as x + SCREEN_W*y, evaluated at ADDR_W bits with no truncation of in-bounds results.
REQ-025 SHALL treat a boid as in-bounds when x < SCREEN_W and y < SCREEN_H.
- In-bounds boid: fb_we=1, fb_data=boid_color, table entry set to {1, addr}.
- Out-of-bounds boid: fb_we=0, table entry set to {0, -}, skip_count incremented, saturating at 255.
REQ-026 SHALL leave colliding boids (same address) to write in index order, so the higher index wins; no arbitration.
REQ-027 SHALL go from DRAW to FIN; FIN lasts one cycle with done=1 and busy=0, then returns to IDLE unless a frame_start is accepted in that cycle.
REQ-028 SHALL drive busy=1 in CLEAR, ERASE and DRAW only.
REQ-029 SHALL hold fb_we=0 in IDLE and FIN; fb_addr and fb_data are don't-care whenever fb_we=0.
REQ-030 SHALL set overrun on frame_start while busy=1 and otherwise ignore that frame_start; overrun stays set until reset.
REQ-031 SHALL treat the first frame after reset as having an all-invalid table, so ERASE writes nothing.

Reset
REQ-032 SHALL, on reset=1 at a rising edge, enter IDLE and clear all table valid bits.
- Outputs become busy=0, done=0, fb_we=0, boid_sel=0, skip_count=0, overrun=0.
REQ-033 SHALL let reset abort any state immediately, with no write issued in the cycle after reset is sampled; framebuffer contents are not restored.
REQ-034 SHALL let reset override a simultaneous frame_start.

Verification (NUM_BOIDS=4, CLEAR_MODE=0 unless noted)
REQ-035 First frame, boids (0,0), (639,479), (10,2), (5,5): ERASE gives 4 cycles with fb_we=0; DRAW writes addresses 0, 307199, 1290, 3205; done appears 10 cycles after frame_start; skip_count=0.
REQ-036 Second frame, boid 1 moved to (700,3): ERASE writes CLEAR_COLOR to 0, 307199, 1290, 3205; DRAW skips boid 1; skip_count=1; the third frame's ERASE has fb_we=0 for entry 1.
REQ-037 frame_start pulsed 3 cycles after an accepted frame_start: overrun=1, no extra rebuild, and done is pulsed exactly once.
REQ-038 frame_start in the FIN cycle: accepted, done=1 in that cycle, and busy=1 in the next cycle.
REQ-039 Reset asserted in draw cycle 2: fb_we=0 from the next cycle onward; the following frame's ERASE writes nothing.
REQ-040 CLEAR_MODE=1, SCREEN_W=8, SCREEN_H=4: 32 consecutive clear writes to addresses 0..31, then 5 DRAW cycles, then done.
